// File: rtl/mem_access_stage.sv
// Purpose : memory-access pipeline stage; issues one 64-bit load/store per instruction, resolves CBZ.
// Latency : non-memory ops 1 cycle; aligned access k+3 cycles (ready k cycles after req); misaligned 2.
// Backpres: stall_M holds upstream while an access is pending; dm_req held stable until dm_ready or timeout.
// Ports   : execute-side inputs (valid_M, MemRead/MemWrite/Branch, zero_M, aluResult_M, writeData_M,
//           PCBranch_M); data-memory req/ready bus (dm_*); results readData_M, PCSrc_M, PCBranch_out,
//           and status stall_M / done_M / mem_err_M.
module mem_access_stage #(
  parameter int N       = 64,
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         valid_M,
  input  logic         MemRead,
  input  logic         MemWrite,
  input  logic         Branch,
  input  logic         zero_M,
  input  logic [N-1:0] aluResult_M,
  input  logic [N-1:0] writeData_M,
  input  logic [N-1:0] PCBranch_M,
  output logic         dm_req,
  output logic         dm_we,
  output logic [N-1:0] dm_addr,
  output logic [N-1:0] dm_wdata,
  input  logic         dm_ready,
  input  logic [N-1:0] dm_rdata,
  output logic [N-1:0] readData_M,
  output logic         PCSrc_M,
  output logic [N-1:0] PCBranch_out,
  output logic         stall_M,
  output logic         done_M,
  output logic         mem_err_M
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  // Counter value of the last BUSY cycle allowed before the access is aborted.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t       state_q, state_d;
  logic [N-1:0] addr_q, addr_d;
  logic [N-1:0] wdata_q, wdata_d;
  logic         we_q, we_d;
  logic [7:0]   cnt_q, cnt_d;
  logic [N-1:0] rdata_q, rdata_d;
  logic         err_q, err_d;

  logic mem_op;
  logic aligned;

  assign mem_op  = valid_M & (MemRead | MemWrite);
  assign aligned = (aluResult_M[2:0] == 3'b000);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (mem_op) begin
          if (aligned) begin
            addr_d  = aluResult_M;
            wdata_d = writeData_M;
            we_d    = MemWrite;     // both set -> store
            cnt_d   = 8'd0;
            state_d = BUSY;
          end else begin
            rdata_d = '0;
            err_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      BUSY: begin
        // Ready in the final allowed cycle still counts as a normal completion.
        if (dm_ready) begin
          if (!we_q) rdata_d = dm_rdata;
          err_d   = 1'b0;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      cnt_q   <= 8'd0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // dm_req decodes the state register directly, so an async reset drops it at once.
  assign dm_req       = (state_q == BUSY);
  assign dm_we        = we_q;
  assign dm_addr      = addr_q;
  assign dm_wdata     = wdata_q;
  assign readData_M   = rdata_q;
  assign PCSrc_M      = valid_M & Branch & zero_M;
  assign PCBranch_out = PCBranch_M;
  assign stall_M      = ((state_q == IDLE) & mem_op) | (state_q == BUSY);
  assign done_M       = (state_q == DONE) | ((state_q == IDLE) & valid_M & ~mem_op);
  assign mem_err_M    = (state_q == DONE) & err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;
  localparam int N = 64;
  localparam int T = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         valid_M, MemRead, MemWrite, Branch, zero_M;
  logic [N-1:0] aluResult_M, writeData_M, PCBranch_M;
  logic         dm_req, dm_we, dm_ready;
  logic [N-1:0] dm_addr, dm_wdata, dm_rdata;
  logic [N-1:0] readData_M, PCBranch_out;
  logic         PCSrc_M, stall_M, done_M, mem_err_M;

  int n_vec = 0;
  int n_err = 0;
  logic [N-1:0] rd_model;

  always #5 clk = ~clk;

  mem_access_stage #(.N(N), .TIMEOUT(T)) dut (
    .clk(clk), .reset(reset), .valid_M(valid_M), .MemRead(MemRead), .MemWrite(MemWrite),
    .Branch(Branch), .zero_M(zero_M), .aluResult_M(aluResult_M), .writeData_M(writeData_M),
    .PCBranch_M(PCBranch_M), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_ready(dm_ready), .dm_rdata(dm_rdata), .readData_M(readData_M),
    .PCSrc_M(PCSrc_M), .PCBranch_out(PCBranch_out), .stall_M(stall_M), .done_M(done_M),
    .mem_err_M(mem_err_M)
  );

  // Drives one instruction and acts as the data memory: ready is returned k cycles after
  // req rises. Measures cycles to done, stall/req cycle counts and the bus contents.
  task automatic run_instr(input logic rd, input logic wr, input logic br, input logic z,
                           input logic [N-1:0] addr, input logic [N-1:0] wd,
                           input logic [N-1:0] tgt, input logic [N-1:0] rdat,
                           input int k, input bit noise,
                           output int cyc, output int st, output int rq, output logic err,
                           output logic [N-1:0] rdo, output bit bus_ok,
                           output logic pcs, output logic [N-1:0] pcb);
    bit fin;
    cyc = 0; st = 0; rq = 0; err = 1'bx; rdo = 'x; bus_ok = 1'b1; pcs = 1'bx; pcb = 'x;
    fin = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 64 && !fin; i++) begin
      valid_M = 1'b1; MemRead = rd; MemWrite = wr; Branch = br; zero_M = z;
      aluResult_M = addr; writeData_M = wd; PCBranch_M = tgt;
      dm_ready = 1'b0; dm_rdata = {$urandom, $urandom};
      #1;
      if (dm_req) begin
        if (dm_addr !== addr || dm_we !== wr || dm_wdata !== wd) bus_ok = 1'b0;
        dm_ready = (rq == k);
        if (dm_ready) dm_rdata = rdat;
        rq++;
        if (noise) begin
          aluResult_M = {$urandom, $urandom};
          writeData_M = {$urandom, $urandom};
        end
      end else if (noise) begin
        dm_ready = 1'($urandom_range(0, 1));
      end
      if (i == 0) begin pcs = PCSrc_M; pcb = PCBranch_out; end
      if (stall_M) st++;
      if (done_M) begin fin = 1'b1; cyc = i + 1; err = mem_err_M; rdo = readData_M; end
      @(negedge clk);
    end
    valid_M = 1'b0; dm_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; valid_M = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; Branch = 1'b0;
    aluResult_M = 64'h10; #1;
    n_vec++; if (done_M !== 1'b1) begin n_err++; $display("FAIL reset_done got %b want 1", done_M); end
    n_vec++; if (stall_M !== 1'b0) begin n_err++; $display("FAIL reset_stall got %b want 0", stall_M); end
    n_vec++; if (dm_req !== 1'b0 || dm_we !== 1'b0) begin n_err++; $display("FAIL reset_req_we got %b%b want 00", dm_req, dm_we); end
    n_vec++; if (dm_addr !== '0 || dm_wdata !== '0) begin n_err++; $display("FAIL reset_bus got %h/%h want 0/0", dm_addr, dm_wdata); end
    n_vec++; if (readData_M !== '0) begin n_err++; $display("FAIL reset_rdata got %h want 0", readData_M); end
    n_vec++; if (mem_err_M !== 1'b0) begin n_err++; $display("FAIL reset_err got %b want 0", mem_err_M); end
    MemRead = 1'b1;
    @(posedge clk); #1;
    n_vec++; if (stall_M !== 1'b1) begin n_err++; $display("FAIL reset_stall_memop got %b want 1", stall_M); end
    n_vec++; if (dm_req !== 1'b0) begin n_err++; $display("FAIL reset_hold_idle got %b want 0", dm_req); end
    @(negedge clk);
    valid_M = 1'b0; MemRead = 1'b0; reset = 1'b0;
    rd_model = '0;
  endtask

  task automatic test_aligned_load;
    int cyc, st, rq; logic err, pcs; logic [N-1:0] rdo, pcb; bit ok;
    run_instr(1, 0, 0, 0, 64'h10, 64'h0, 64'h0, 64'hDEADBEEF, 2, 0, cyc, st, rq, err, rdo, ok, pcs, pcb);
    rd_model = 64'hDEADBEEF;
    n_vec++; if (cyc !== 5) begin n_err++; $display("FAIL load_cycles got %0d want 5", cyc); end
    n_vec++; if (st !== 4) begin n_err++; $display("FAIL load_stall got %0d want 4", st); end
    n_vec++; if (rq !== 3) begin n_err++; $display("FAIL load_req got %0d want 3", rq); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL load_err got %b want 0", err); end
    n_vec++; if (rdo !== rd_model) begin n_err++; $display("FAIL load_rdata got %h want %h", rdo, rd_model); end
    n_vec++; if (!ok) begin n_err++; $display("FAIL load_bus got mismatch want addr 10 we 0"); end
  endtask

  task automatic test_store_same_cycle;
    int cyc, st, rq; logic err, pcs; logic [N-1:0] rdo, pcb; bit ok;
    run_instr(0, 1, 0, 0, 64'h20, 64'h55, 64'h0, 64'hFFFF, 0, 0, cyc, st, rq, err, rdo, ok, pcs, pcb);
    n_vec++; if (cyc !== 3) begin n_err++; $display("FAIL store_cycles got %0d want 3", cyc); end
    n_vec++; if (rq !== 1) begin n_err++; $display("FAIL store_req got %0d want 1", rq); end
    n_vec++; if (!ok) begin n_err++; $display("FAIL store_bus got mismatch want we 1 addr 20 data 55"); end
    n_vec++; if (rdo !== rd_model) begin n_err++; $display("FAIL store_rdata got %h want %h", rdo, rd_model); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL store_err got %b want 0", err); end
  endtask

  task automatic test_misaligned;
    int cyc, st, rq; logic err, pcs; logic [N-1:0] rdo, pcb; bit ok;
    run_instr(1, 0, 0, 0, 64'h13, 64'h0, 64'h0, 64'h0, 0, 0, cyc, st, rq, err, rdo, ok, pcs, pcb);
    rd_model = '0;
    n_vec++; if (cyc !== 2) begin n_err++; $display("FAIL mis_cycles got %0d want 2", cyc); end
    n_vec++; if (rq !== 0) begin n_err++; $display("FAIL mis_req got %0d want 0", rq); end
    n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL mis_err got %b want 1", err); end
    n_vec++; if (rdo !== '0) begin n_err++; $display("FAIL mis_rdata got %h want 0", rdo); end
  endtask

  task automatic test_timeout;
    int cyc, st, rq; logic err, pcs; logic [N-1:0] rdo, pcb; bit ok;
    // Ready on the last allowed BUSY cycle completes normally.
    run_instr(1, 0, 0, 0, 64'h100, 64'h0, 64'h0, 64'h1234, T - 1, 0, cyc, st, rq, err, rdo, ok, pcs, pcb);
    rd_model = 64'h1234;
    n_vec++; if (cyc !== T + 2) begin n_err++; $display("FAIL edge_cycles got %0d want %0d", cyc, T + 2); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL edge_err got %b want 0", err); end
    n_vec++; if (rdo !== rd_model) begin n_err++; $display("FAIL edge_rdata got %h want %h", rdo, rd_model); end
    run_instr(1, 0, 0, 0, 64'h108, 64'h0, 64'h0, 64'h9, 1000, 0, cyc, st, rq, err, rdo, ok, pcs, pcb);
    rd_model = '0;
    n_vec++; if (rq !== T) begin n_err++; $display("FAIL tmo_req got %0d want %0d", rq, T); end
    n_vec++; if (cyc !== T + 2) begin n_err++; $display("FAIL tmo_cycles got %0d want %0d", cyc, T + 2); end
    n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL tmo_err got %b want 1", err); end
    n_vec++; if (rdo !== '0) begin n_err++; $display("FAIL tmo_rdata got %h want 0", rdo); end
  endtask

  task automatic test_branch;
    int cyc, st, rq; logic err, pcs; logic [N-1:0] rdo, pcb; bit ok;
    run_instr(0, 0, 1, 1, 64'h0, 64'h0, 64'h40, 64'h0, 0, 0, cyc, st, rq, err, rdo, ok, pcs, pcb);
    n_vec++; if (pcs !== 1'b1) begin n_err++; $display("FAIL br_taken got %b want 1", pcs); end
    n_vec++; if (pcb !== 64'h40) begin n_err++; $display("FAIL br_target got %h want 40", pcb); end
    n_vec++; if (cyc !== 1 || st !== 0) begin n_err++; $display("FAIL br_done got cyc %0d stall %0d want 1/0", cyc, st); end
    run_instr(0, 0, 1, 0, 64'h0, 64'h0, 64'h40, 64'h0, 0, 0, cyc, st, rq, err, rdo, ok, pcs, pcb);
    n_vec++; if (pcs !== 1'b0) begin n_err++; $display("FAIL br_not_taken got %b want 0", pcs); end
  endtask

  task automatic test_reset_mid_access;
    @(negedge clk);
    valid_M = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; Branch = 1'b0; aluResult_M = 64'h8; dm_ready = 1'b0;
    @(posedge clk); @(negedge clk); #1;
    n_vec++; if (dm_req !== 1'b1) begin n_err++; $display("FAIL rst_busy1 got %b want 1", dm_req); end
    @(posedge clk); @(negedge clk); #1;
    reset = 1'b1; #1;
    n_vec++; if (dm_req !== 1'b0) begin n_err++; $display("FAIL rst_async_req got %b want 0", dm_req); end
    n_vec++; if (done_M !== 1'b0) begin n_err++; $display("FAIL rst_no_done got %b want 0", done_M); end
    n_vec++; if (stall_M !== 1'b1) begin n_err++; $display("FAIL rst_idle_stall got %b want 1", stall_M); end
    valid_M = 1'b0; MemRead = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    rd_model = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      n_vec++; if (done_M !== 1'b0 || mem_err_M !== 1'b0 || dm_req !== 1'b0) begin
        n_err++; $display("FAIL rst_after got done %b err %b req %b want 000", done_M, mem_err_M, dm_req); end
    end
    n_vec++; if (readData_M !== '0) begin n_err++; $display("FAIL rst_rdata got %h want 0", readData_M); end
  endtask

  task automatic test_random;
    int cyc, st, rq, k, kind; logic err, pcs, rd, wr, br, z; logic [N-1:0] rdo, pcb, addr, wd, tgt, rdat;
    int e_cyc, e_st, e_rq; logic e_err; bit ok;
    for (int n = 0; n < 150; n++) begin
      kind = $urandom_range(0, 5); k = $urandom_range(0, T + 2);
      rd = 0; wr = 0; br = 0; z = 1'($urandom_range(0, 1));
      addr = {$urandom, $urandom} & ~64'h7; wd = {$urandom, $urandom};
      tgt = {$urandom, $urandom}; rdat = {$urandom, $urandom};
      case (kind)
        1: br = 1;
        2: rd = 1;
        3: wr = 1;
        4: begin rd = 1; wr = 1; end
        5: begin rd = 1'($urandom_range(0, 1)); wr = ~rd; addr[2:0] = 3'($urandom_range(1, 7)); end
        default: ;
      endcase
      // Reference: latency/outcome straight from the access rules.
      if (!(rd || wr)) begin e_cyc = 1; e_st = 0; e_rq = 0; e_err = 0; end
      else if (addr[2:0] != 0) begin e_cyc = 2; e_st = 1; e_rq = 0; e_err = 1; rd_model = '0; end
      else if (k < T) begin e_cyc = k + 3; e_st = k + 2; e_rq = k + 1; e_err = 0; if (!wr) rd_model = rdat; end
      else begin e_cyc = T + 2; e_st = T + 1; e_rq = T; e_err = 1; rd_model = '0; end
      run_instr(rd, wr, br, z, addr, wd, tgt, rdat, k, 1, cyc, st, rq, err, rdo, ok, pcs, pcb);
      n_vec++; if (cyc !== e_cyc || st !== e_st || rq !== e_rq) begin n_err++;
        $display("FAIL rnd%0d_timing got cyc %0d stall %0d req %0d want %0d %0d %0d", n, cyc, st, rq, e_cyc, e_st, e_rq); end
      n_vec++; if (err !== e_err) begin n_err++; $display("FAIL rnd%0d_err got %b want %b", n, err, e_err); end
      n_vec++; if (rdo !== rd_model) begin n_err++; $display("FAIL rnd%0d_rdata got %h want %h", n, rdo, rd_model); end
      n_vec++; if (!ok) begin n_err++; $display("FAIL rnd%0d_bus got unstable/wrong want addr %h data %h", n, addr, wd); end
      n_vec++; if (pcs !== (br & z) || pcb !== tgt) begin n_err++;
        $display("FAIL rnd%0d_branch got %b %h want %b %h", n, pcs, pcb, br & z, tgt); end
    end
  endtask

  initial begin
    reset = 1'b1; valid_M = 0; MemRead = 0; MemWrite = 0; Branch = 0; zero_M = 0;
    aluResult_M = '0; writeData_M = '0; PCBranch_M = '0; dm_ready = 0; dm_rdata = '0;
    rd_model = '0;
    test_reset;
    test_aligned_load;
    test_store_same_cycle;
    test_misaligned;
    test_timeout;
    test_branch;
    test_reset_mid_access;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access stage placed directly downstream of the execute stage. It consumes the ALU result, store data, zero flag and branch target produced by execute, issues at most one 64-bit load or store per instruction to a variable-latency data memory over a req/ready handshake, and stalls upstream stages until that access finishes. It also resolves the branch decision (`PCSrc_M`) for fetch, and reports misaligned and timed-out accesses.

## Interface
- `N`, 64, datapath width (address and data).
- `TIMEOUT`, 16, maximum cycles spent in BUSY before the access is aborted (range 2..255).
- `clk` in 1: single clock, all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `valid_M` in 1: an instruction is present at the stage inputs.
- `MemRead` in 1: the instruction is a load (LDUR).
- `MemWrite` in 1: the instruction is a store (STUR).
- `Branch` in 1: the instruction is a conditional branch (CBZ).
- `zero_M` in 1: zero flag from execute.
- `aluResult_M` in N: effective address from execute.
- `writeData_M` in N: store data from execute.
- `PCBranch_M` in N: branch target from execute.
- `dm_req` out 1: memory request.
- `dm_we` out 1: write enable, valid while `dm_req` is high.
- `dm_addr` out N: memory address.
- `dm_wdata` out N: store data.
- `dm_ready` in 1: memory completion; sampled only in BUSY.
- `dm_rdata` in N: load data, valid in the same cycle as `dm_ready`.
- `readData_M` out N: registered load result.
- `PCSrc_M` out 1: take the branch.
- `PCBranch_out` out N: pass-through of `PCBranch_M`.
- `stall_M` out 1: hold all upstream stages and keep the inputs stable.
- `done_M` out 1: the instruction at the inputs completes this cycle.
- `mem_err_M` out 1: the completing access was misaligned or timed out.

## Operation
- A memory op is `valid_M & (MemRead | MemWrite)`. If both `MemRead` and `MemWrite` are set, the access is treated as a store.
- FSM states: IDLE, BUSY, DONE.
- **IDLE, memory op, aligned** (`aluResult_M[2:0]==0`):
  - Latch the address, write data and the we-bit into registers.
  - Clear the counter.
  - Next state is BUSY.
- **IDLE, memory op, misaligned:**
  - No request is issued.
  - `readData_M` <= 0 and the error bit is set.
  - Next state is DONE.
- **IDLE, no memory op:** remain in IDLE.
- **BUSY:**
  - `dm_req`=1, driven from the latched registers; these stay stable for the whole state.
  - If `dm_ready`=1: `readData_M` <= `dm_rdata` on loads (unchanged on stores), error bit cleared, next state DONE.
  - Otherwise the counter increments. When the counter reaches `TIMEOUT-1` without ready: `readData_M` <= 0, error bit set, next state DONE.
- **DONE:** after one cycle, return to IDLE unconditionally.
- `stall_M` = (IDLE & memory op) | BUSY. It is low in DONE.
- `done_M` = DONE | (IDLE & `valid_M` & no memory op).
- `mem_err_M` = DONE & error bit.
- `PCSrc_M` = `valid_M & Branch & zero_M`. It is combinational and independent of the FSM.
- `dm_we` and `dm_addr`/`dm_wdata` reflect the latched registers. `dm_req`=0 outside BUSY.

## Timing
- Reset values:
  - State is IDLE.
  - `dm_req`=0, `dm_we`=0, `dm_addr`=0, `dm_wdata`=0.
  - `readData_M`=0, error bit 0, counter 0.
  - `done_M` follows `valid_M` with no memory op; `stall_M` follows the memory-op condition.
- Latency for a memory op whose `dm_ready` arrives k cycles after `dm_req` rises (k>=0, same-cycle ready allowed): 1 (IDLE) + (k+1) (BUSY) + 1 (DONE) = k+3 cycles of `valid_M`. `stall_M` is high for the first k+2 of them.
- Non-memory instructions and branches complete in 1 cycle with no stall.
- A timeout is declared after exactly `TIMEOUT` BUSY cycles with no ready.
- `dm_ready` is ignored in IDLE and DONE. `dm_ready` in the timeout cycle wins: the access is treated as a normal completion.
- `readData_M` holds its value until the next load completes or an error occurs.
- A reset asserted in BUSY drops `dm_req` immediately (asynchronously) and abandons the access. No completion is reported.
- The upstream must keep the inputs constant while `stall_M`=1. Changes to the inputs during BUSY are ignored.

## Test plan
- **Aligned load:** reset, then `MemRead`=1, addr 0x10. Memory returns `dm_rdata`=0xDEADBEEF with `dm_ready` 2 cycles after `dm_req`. Required: `stall_M` high for 4 cycles, then `done_M`=1, `readData_M`=0xDEADBEEF, `mem_err_M`=0.
- **Store with same-cycle ready:** `MemWrite`=1, addr 0x20, data 0x55. Required: `dm_we`=1, `dm_addr`=0x20, `dm_wdata`=0x55 with `dm_req` high for 1 cycle, `done_M` on the 3rd cycle, `readData_M` unchanged.
- **Misaligned load:** addr 0x13. Required: `dm_req` never asserted, `done_M`=`mem_err_M`=1 on cycle 2, `readData_M`=0.
- **Timeout:** `TIMEOUT`=4, `dm_ready` held at 0. Required: `dm_req` high for exactly 4 cycles, then `mem_err_M`=1 and `readData_M`=0.
- **Branch:** `Branch`=1 with `zero_M`=1, target 0x40. Required: `PCSrc_M`=1, `PCBranch_out`=0x40, `done_M`=1, `stall_M`=0. Repeat with `zero_M`=0: `PCSrc_M`=0.
- **Reset mid-access:** assert `reset` in the 2nd BUSY cycle. Required: `dm_req` falls without waiting for a clock edge, state returns to IDLE, no `done_M` is reported for the abandoned access.
